// File: rtl/ring_buffer_unloader.sv
// ring_buffer_unloader: streams each 8-beat burst from the DDR read ring buffer to the host return path (`define RB_UNLOAD_PARITY_EN adds out_par)
module ring_buffer_unloader #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fill_done,
    input  logic [PTR_W-1:0] start_ptr,
    output logic [PTR_W-1:0] readPtr,
    input  logic [WIDTH-1:0] rb_dout,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             overrun
`ifdef RB_UNLOAD_PARITY_EN
    ,output logic            out_par
`endif
);
    typedef enum logic [1:0] {IDLE, UNLOAD, DRAIN} state_t;
    localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] RECV_LAST = PTR_W'(DEPTH - 1);
    state_t           state, state_nxt;
    logic [PTR_W:0]   issue_cnt, issue_cnt_nxt;
    logic [PTR_W-1:0] recv_cnt, ptr_nxt;
    logic             rd_q, rd_nxt, xfer, load_out, skid_valid, skid_en, issue;
    logic [1:0]       held;
    logic [WIDTH-1:0] skid_data, out_nxt;

    assign busy     = state != IDLE;
    assign out_last = out_valid && recv_cnt == RECV_LAST;

    // next state, read issue under credit, and routing of captured data
    always_comb begin
        xfer          = out_valid && out_ready;
        load_out      = !out_valid || xfer;
        held          = 2'(out_valid) + 2'(skid_valid) + 2'(rd_q) - 2'(xfer);
        issue         = state == UNLOAD && issue_cnt < CNT_FULL && held < 2'd2;
        out_nxt       = skid_valid ? skid_data : rb_dout;
        skid_en       = rd_q && (skid_valid || !load_out);
        state_nxt     = state;
        ptr_nxt       = issue ? readPtr + PTR_W'(1) : readPtr;
        issue_cnt_nxt = issue ? issue_cnt + (PTR_W+1)'(1) : issue_cnt;
        rd_nxt        = issue;
        if (state == IDLE && fill_done) begin
            state_nxt     = UNLOAD;
            ptr_nxt       = start_ptr;
            issue_cnt_nxt = (PTR_W+1)'(1);
            rd_nxt        = 1'b1;
        end
        if (state == UNLOAD && issue_cnt == CNT_FULL) state_nxt = DRAIN;
        if (state == DRAIN && xfer && out_last) state_nxt = IDLE;
    end

    // state, read pointer, output register, skid register and sticky overrun
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            readPtr    <= '0;
            issue_cnt  <= '0;
            recv_cnt   <= '0;
            rd_q       <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef RB_UNLOAD_PARITY_EN
            out_par    <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            readPtr    <= ptr_nxt;
            issue_cnt  <= issue_cnt_nxt;
            rd_q       <= rd_nxt;
            if (xfer) recv_cnt <= recv_cnt + PTR_W'(1);
            if (load_out) out_valid <= skid_valid || rd_q;
            if (load_out && (skid_valid || rd_q)) out_data <= out_nxt;
`ifdef RB_UNLOAD_PARITY_EN
            if (load_out && (skid_valid || rd_q)) out_par <= ^out_nxt;
`endif
            skid_valid <= load_out ? skid_valid && rd_q : skid_valid || rd_q;
            if (skid_en) skid_data <= rb_dout;
            if (fill_done && state != IDLE) overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ring_buffer_unloader.sv
// tb_ring_buffer_unloader: scoreboard bench for ring_buffer_unloader
module tb_ring_buffer_unloader;
    logic        clk = 0;
    logic        reset = 0;
    logic        fill_done = 0;
    logic [2:0]  start_ptr = 0;
    logic [2:0]  readPtr;
    logic [15:0] rb_dout;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        overrun;
`ifdef RB_UNLOAD_PARITY_EN
    logic        out_par;
`endif

    logic [15:0] mem [8];
    logic [16:0] sb [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          issued, delivered, cyc;
    logic        seen_v, prev_busy, prev_stall, prev_last, bp_en;
    logic [15:0] prev_data;
    logic [2:0]  prev_ptr, exp_start;
    logic [7:0]  bp_pat = 8'b1110_1001;

    ring_buffer_unloader dut (
        .clk(clk), .reset(reset), .fill_done(fill_done), .start_ptr(start_ptr),
        .readPtr(readPtr), .rb_dout(rb_dout), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .overrun(overrun)
`ifdef RB_UNLOAD_PARITY_EN
        , .out_par(out_par)
`endif
    );

    assign rb_dout = mem[readPtr];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic burst(input logic [2:0] p);
        exp_start = p;
        for (int i = 0; i < 8; i++) sb.push_back({i == 7, mem[3'(p + 3'(i))]});
        start_ptr = p;
        fill_done = 1;
        @(posedge clk);
        #1 fill_done = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((busy || sb.size() != 0) && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        check("done_timeout", 32'(n < 200), 1);
        check("busy_end", 32'(busy), 0);
    endtask

    initial begin
        out_ready = 1;
        forever begin
            @(posedge clk);
            #1 out_ready = bp_en ? bp_pat[3'(cyc)] : 1'b1;
        end
    end

    initial begin
        logic [2:0] nxt;
        logic [16:0] e;
        prev_busy = 0;
        prev_stall = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_busy = 0;
                prev_stall = 0;
                continue;
            end
            if (busy && !prev_busy) begin
                cyc = 1;
                issued = 1;
                delivered = 0;
                seen_v = 0;
                check("start_ptr", 32'(readPtr), 32'(exp_start));
            end else if (busy) begin
                cyc++;
                if (readPtr != prev_ptr) begin
                    nxt = prev_ptr + 3'd1;
                    check("ptr_step", 32'(readPtr), 32'(nxt));
                    issued++;
                end
            end
            if (busy) check("credit", 32'(issued - delivered <= 2), 1);
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_data", 32'(out_data), 32'(prev_data));
                check("hold_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && busy && !seen_v) begin
                seen_v = 1;
                check("latency", cyc, 2);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("unexpected_word", 32'(out_data), 32'hffff_ffff);
                else begin
                    e = sb.pop_front();
                    check("data", 32'(out_data), 32'(e[15:0]));
                    check("last", 32'(out_last), 32'(e[16]));
`ifdef RB_UNLOAD_PARITY_EN
                    check("parity", 32'(out_par), 32'(^e[15:0]));
`endif
                    if (e[16] && !bp_en) check("burst_len", cyc, 9);
                end
                delivered++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            prev_ptr = readPtr;
            prev_busy = busy;
        end
    end

    initial begin
        int n;
        bp_en = 0;
        cyc = 0;
        for (int i = 0; i < 8; i++) mem[i] = 16'h1000 + 16'(i);
        repeat (3) @(posedge clk);
        #1;
        check("rst_ptr", 32'(readPtr), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_last", 32'(out_last), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        reset = 1;
        @(posedge clk);
        #1;
        burst(0);
        wait_done();
        burst(5);
        wait_done();
        bp_en = 1;
        burst(3);
        wait_done();
        bp_en = 0;
        @(posedge clk);
        #1;
        check("ovr_before", 32'(overrun), 0);
        burst(1);
        repeat (2) @(posedge clk);
        #1 start_ptr = 7;
        fill_done = 1;
        @(posedge clk);
        #1 fill_done = 0;
        check("ovr_set", 32'(overrun), 1);
        wait_done();
        repeat (4) @(posedge clk);
        #1;
        check("ovr_sticky", 32'(overrun), 1);
        check("no_second_burst", 32'(busy), 0);
        burst(6);
        n = 0;
        while (delivered < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mid_wait", 32'(n < 100), 1);
        reset = 0;
        @(posedge clk);
        #1;
        check("mid_ptr", 32'(readPtr), 0);
        check("mid_data", 32'(out_data), 0);
        check("mid_valid", 32'(out_valid), 0);
        check("mid_last", 32'(out_last), 0);
        check("mid_busy", 32'(busy), 0);
        check("mid_overrun", 32'(overrun), 0);
        sb.delete();
        reset = 1;
        @(posedge clk);
        #1;
        burst(2);
        wait_done();
        burst(0);
        n = 0;
        while (!(out_valid && out_last) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("last_wait", 32'(n < 100), 1);
        start_ptr = 4;
        fill_done = 1;
        @(posedge clk);
        #1 fill_done = 0;
        check("late_ovr", 32'(overrun), 1);
        repeat (3) @(posedge clk);
        #1;
        check("late_not_accepted", 32'(busy), 0);
        check("late_sb_empty", 32'(sb.size()), 0);
`ifdef RB_UNLOAD_PARITY_EN
        mem[0] = 16'h0007;
        mem[1] = 16'h0003;
        burst(0);
        wait_done();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
